param_tag_fifo: RTL and testbench

- Parameterised synchronous buffer sitting directly upstream of param_examples_dut.
- Accepts (data, id) pairs from a producer over a valid/ready handshake, stores them in order, and presents them one per cycle to the downstream data/id consumer.
- Widths track the same data_width/id_width pair used by the downstream stage, so one parameter set configures both.

---
 rtl/param_tag_fifo_pkg.sv | 14 +
 rtl/param_tag_fifo_if.sv | 37 +++
 rtl/param_tag_fifo_mem.sv | 24 ++
 rtl/param_tag_fifo.sv | 95 +++++++++
 tb/tb_param_tag_fifo.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/param_tag_fifo_pkg.sv
// Shared defaults and sizing helpers for the tagged show-ahead FIFO.
// Imported by the interface, the storage array and the FIFO top.
package param_tag_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int ID_WIDTH_DEF   = 4;
    localparam int DEPTH_DEF      = 8;

    // Occupancy runs 0..depth, so it needs one bit more than a pointer
    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/param_tag_fifo_if.sv
// Producer/consumer handshake bundle for param_tag_fifo.
// The FIFO uses the slave modport; the driving side uses master.
interface param_tag_fifo_if
    import param_tag_pkg::*;
#(
    parameter int data_width = DATA_WIDTH_DEF,
    parameter int id_width   = ID_WIDTH_DEF,
    parameter int depth      = DEPTH_DEF
);
    localparam int lw = level_width(depth);

    logic                  in_valid;
    logic                  in_ready;
    logic [data_width-1:0] in_data;
    logic [id_width-1:0]   in_id;
    logic                  out_valid;
    logic                  out_ready;
    logic [data_width-1:0] out_data;
    logic [id_width-1:0]   out_id;
    logic [lw-1:0]         level;
    logic                  overflow;
    logic                  underflow;
    logic                  clr_err;

    modport master (
        output in_valid, in_data, in_id, out_ready, clr_err,
        input  in_ready, out_valid, out_data, out_id,
        input  level, overflow, underflow
    );

    modport slave (
        input  in_valid, in_data, in_id, out_ready, clr_err,
        output in_ready, out_valid, out_data, out_id,
        output level, overflow, underflow
    );

endinterface

// File: rtl/param_tag_fifo_mem.sv
// Storage array: one synchronous write port, one asynchronous read port.
// Contents are intentionally not reset.
module param_tag_mem #(
    parameter  int width = 12,
    parameter  int depth = 8,
    localparam int aw    = $clog2(depth)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [aw-1:0]    waddr,
    input  logic [width-1:0] wdata,
    input  logic [aw-1:0]    raddr,
    output logic [width-1:0] rdata
);

    logic [width-1:0] mem_q [depth];

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/param_tag_fifo.sv
// Show-ahead (data, id) FIFO feeding the downstream data/id stage.
// Full/empty come from the occupancy counter; pointers wrap freely.
module param_tag_fifo
    import param_tag_pkg::*;
#(
    parameter  int data_width = DATA_WIDTH_DEF,
    parameter  int id_width   = ID_WIDTH_DEF,
    parameter  int depth      = DEPTH_DEF,
    localparam int addr_width = $clog2(depth)
) (
    input logic              clk,
    input logic              rst,
    param_tag_fifo_if.slave  bus
);

    localparam int lw = level_width(depth);
    localparam int ew = data_width + id_width;

    logic [addr_width-1:0] wr_ptr_q, wr_ptr_d;
    logic [addr_width-1:0] rd_ptr_q, rd_ptr_d;
    logic [lw-1:0]         level_q, level_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;

    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic [ew-1:0] wdata;
    logic [ew-1:0] rdata;

    assign full  = (level_q == lw'(depth));
    assign empty = (level_q == '0);
    assign push  = bus.in_valid && !full;
    assign pop   = bus.out_ready && !empty;
    assign wdata = {bus.in_data, bus.in_id};

    param_tag_mem #(
        .width (ew),
        .depth (depth)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata (wdata),
        .raddr (rd_ptr_q),
        .rdata (rdata)
    );

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        overflow_d  = overflow_q && !bus.clr_err;
        underflow_d = underflow_q && !bus.clr_err;

        if (push) wr_ptr_d = wr_ptr_q + addr_width'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + addr_width'(1);

        unique case ({push, pop})
            2'b10:   level_d = level_q + lw'(1);
            2'b01:   level_d = level_q - lw'(1);
            default: level_d = level_q;
        endcase

        // A new error event in the clearing cycle keeps the flag set
        if (bus.in_valid && full)   overflow_d  = 1'b1;
        if (bus.out_ready && empty) underflow_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign bus.in_ready  = !full;
    assign bus.out_valid = !empty;
    assign bus.out_data  = empty ? '0 : rdata[ew-1:id_width];
    assign bus.out_id    = empty ? '0 : rdata[id_width-1:0];
    assign bus.level     = level_q;
    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;

endmodule

// File: tb/tb_param_tag_fifo.sv
// Randomised bench for param_tag_fifo against a queue-based model.
module tb_param_tag_fifo;

    localparam int DW = 8;
    localparam int IW = 4;
    localparam int DP = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    param_tag_fifo_if #(.data_width(DW), .id_width(IW), .depth(DP)) bus ();

    param_tag_fifo #(.data_width(DW), .id_width(IW), .depth(DP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Model: ordered queue of {data,id} plus two sticky booleans
    logic [DW+IW-1:0] q[$];
    bit m_ovf = 0;
    bit m_unf = 0;

    function automatic logic [DW-1:0] exp_data();
        return (q.size() == 0) ? '0 : q[0][DW+IW-1:IW];
    endfunction

    function automatic logic [IW-1:0] exp_id();
        return (q.size() == 0) ? '0 : q[0][IW-1:0];
    endfunction

    function automatic logic [3:0] exp_level();
        return 4'(q.size());
    endfunction

    task automatic model_reset();
        q.delete();
        m_ovf = 0;
        m_unf = 0;
    endtask

    // Drive one cycle, advance the model with the rules of the buffer
    task automatic cyc(input logic v, input logic [DW-1:0] d,
                       input logic [IW-1:0] id, input logic rdy,
                       input logic clr);
        bit full, empty;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.in_id     = id;
        bus.out_ready = rdy;
        bus.clr_err   = clr;
        @(posedge clk);
        full  = (q.size() == DP);
        empty = (q.size() == 0);
        m_ovf = (m_ovf && !clr) || (v && full);
        m_unf = (m_unf && !clr) || (rdy && empty);
        if (rdy && !empty) void'(q.pop_front());
        if (v && !full) q.push_back({d, id});
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < DP + 1; i++) cyc(1'b0, '0, '0, 1'b1, 1'b0);
        cyc(1'b0, '0, '0, 1'b0, 1'b1);
    endtask

    task automatic test_reset();
        bus.in_valid = 0; bus.in_data = 0; bus.in_id = 0;
        bus.out_ready = 0; bus.clr_err = 0;
        rst = 1'b1;
        #12;
        checks++;
        if (bus.level !== 4'd0 || bus.out_valid !== 1'b0 ||
            bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ctrl: level=%0d ov=%b ir=%b want 0/0/1",
                     bus.level, bus.out_valid, bus.in_ready);
        end
        checks++;
        if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0 ||
            bus.out_data !== 8'h00 || bus.out_id !== 4'h0) begin
            errors++;
            $display("FAIL reset_out: ovf=%b unf=%b d=%h id=%h want 0",
                     bus.overflow, bus.underflow, bus.out_data, bus.out_id);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        idle();
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < DP; i++)
            cyc(1'b1, 8'(8'h10 + i), 4'(i + 1), 1'b0, 1'b0);
        checks++;
        if (bus.level !== 4'd8 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL fill: level=%0d ir=%b want 8/0",
                     bus.level, bus.in_ready);
        end
        for (int i = 0; i < DP; i++) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== 8'(8'h10 + i) ||
                bus.out_id !== 4'(i + 1)) begin
                errors++;
                $display("FAIL drain_%0d: v=%b %h/%h want 1 %h/%h", i,
                         bus.out_valid, bus.out_data, bus.out_id,
                         8'(8'h10 + i), 4'(i + 1));
            end
            cyc(1'b0, '0, '0, 1'b1, 1'b0);
        end
        checks++;
        if (bus.level !== 4'd0 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL drained: level=%0d ov=%b want 0/0",
                     bus.level, bus.out_valid);
        end
        idle();
    endtask

    task automatic test_latency();
        bus.in_valid = 1; bus.in_data = 8'hA5; bus.in_id = 4'd3;
        #2;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h00) begin
            errors++;
            $display("FAIL flow_through: v=%b d=%h want 0/00",
                     bus.out_valid, bus.out_data);
        end
        cyc(1'b1, 8'hA5, 4'd3, 1'b0, 1'b0);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hA5 ||
            bus.out_id !== 4'd3 || bus.level !== 4'd1) begin
            errors++;
            $display("FAIL latency: v=%b %h/%h lvl=%0d want 1 a5/3 1",
                     bus.out_valid, bus.out_data, bus.out_id, bus.level);
        end
        drain();
    endtask

    task automatic test_overflow();
        logic [DW-1:0] hd;
        logic [IW-1:0] hi;
        for (int i = 0; i < DP; i++)
            cyc(1'b1, 8'($urandom_range(0, 8'hFE)), 4'($urandom), 1'b0, 1'b0);
        hd = exp_data();
        hi = exp_id();
        cyc(1'b1, 8'hFF, 4'hF, 1'b0, 1'b0);
        checks++;
        if (bus.overflow !== 1'b1 || bus.level !== 4'd8 ||
            bus.out_data !== hd || bus.out_id !== hi) begin
            errors++;
            $display("FAIL overflow: ovf=%b lvl=%0d %h/%h want 1 8 %h/%h",
                     bus.overflow, bus.level, bus.out_data, bus.out_id,
                     hd, hi);
        end
        cyc(1'b0, '0, '0, 1'b0, 1'b1);
        checks++;
        if (bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear: ovf=%b want 0", bus.overflow);
        end
        // Pop while full with a push attempt: pop only
        cyc(1'b1, 8'hFF, 4'hF, 1'b1, 1'b0);
        checks++;
        if (bus.level !== 4'd7 || bus.overflow !== 1'b1 ||
            bus.out_data !== exp_data()) begin
            errors++;
            $display("FAIL full_pushpop: lvl=%0d ovf=%b d=%h want 7 1 %h",
                     bus.level, bus.overflow, bus.out_data, exp_data());
        end
        for (int i = 0; i < DP - 1; i++) begin
            checks++;
            if (bus.out_data === 8'hFF || bus.out_data !== exp_data() ||
                bus.out_id !== exp_id()) begin
                errors++;
                $display("FAIL ovf_drain_%0d: %h/%h want %h/%h", i,
                         bus.out_data, bus.out_id, exp_data(), exp_id());
            end
            cyc(1'b0, '0, '0, 1'b1, 1'b0);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++)
            cyc(1'b1, 8'($urandom), 4'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (bus.out_data !== exp_data() || bus.out_id !== exp_id()) begin
                errors++;
                $display("FAIL b2b_order_%0d: %h/%h want %h/%h", i,
                         bus.out_data, bus.out_id, exp_data(), exp_id());
            end
            cyc(1'b1, 8'($urandom), 4'($urandom), 1'b1, 1'b0);
            checks++;
            if (bus.level !== 4'd4) begin
                errors++;
                $display("FAIL b2b_level_%0d: lvl=%0d want 4", i, bus.level);
            end
        end
        drain();
    endtask

    task automatic test_underflow();
        cyc(1'b0, '0, '0, 1'b1, 1'b0);
        checks++;
        if (bus.underflow !== 1'b1 || bus.level !== 4'd0) begin
            errors++;
            $display("FAIL underflow: unf=%b lvl=%0d want 1/0",
                     bus.underflow, bus.level);
        end
        cyc(1'b0, '0, '0, 1'b1, 1'b1);
        checks++;
        if (bus.underflow !== 1'b1) begin
            errors++;
            $display("FAIL unf_setwins: unf=%b want 1", bus.underflow);
        end
        // Empty pop with a push in the same cycle: push still lands
        cyc(1'b1, 8'h3C, 4'd6, 1'b1, 1'b1);
        checks++;
        if (bus.underflow !== 1'b1 || bus.level !== 4'd1 ||
            bus.out_data !== 8'h3C) begin
            errors++;
            $display("FAIL unf_push: unf=%b lvl=%0d d=%h want 1 1 3c",
                     bus.underflow, bus.level, bus.out_data);
        end
        drain();
        checks++;
        if (bus.underflow !== m_unf || m_unf) begin
            errors++;
            $display("FAIL unf_clear: unf=%b want 0", bus.underflow);
        end
    endtask

    task automatic test_async_reset();
        cyc(1'b0, '0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++)
            cyc(1'b1, 8'($urandom), 4'($urandom), 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.level !== 4'd0 || bus.out_valid !== 1'b0 ||
            bus.underflow !== 1'b0 || bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL async_rst: lvl=%0d v=%b unf=%b ovf=%b want 0",
                     bus.level, bus.out_valid, bus.underflow, bus.overflow);
        end
        @(posedge clk);
        #3;
        rst = 1'b0;
        model_reset();
        cyc(1'b1, 8'h77, 4'd9, 1'b0, 1'b0);
        checks++;
        if (bus.level !== 4'd1 || bus.out_data !== 8'h77 ||
            bus.out_id !== 4'd9) begin
            errors++;
            $display("FAIL post_rst: lvl=%0d %h/%h want 1 77/9",
                     bus.level, bus.out_data, bus.out_id);
        end
        drain();
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            cyc(1'($urandom_range(0, 99) < 60), 8'($urandom), 4'($urandom),
                1'($urandom_range(0, 99) < 45), 1'($urandom_range(0, 9) == 0));
            checks++;
            if (bus.level !== exp_level() ||
                bus.out_valid !== (q.size() != 0) ||
                bus.in_ready !== (q.size() != DP) ||
                bus.out_data !== exp_data() || bus.out_id !== exp_id() ||
                bus.overflow !== m_ovf || bus.underflow !== m_unf) begin
                errors++;
                $display("FAIL rand_%0d: lvl=%0d %h/%h o=%b u=%b want %0d %h/%h o=%b u=%b",
                         i, bus.level, bus.out_data, bus.out_id,
                         bus.overflow, bus.underflow, exp_level(),
                         exp_data(), exp_id(), m_ovf, m_unf);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_latency();
        test_overflow();
        test_back_to_back();
        test_underflow();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
